// File: rtl/rx_cpu_arb_pkg.sv
// Shared types and constants for the CPU RX admission arbiter.
package rx_cpu_arb_pkg;

  typedef enum logic [2:0] {IDLE, SIZE, CHECK, XFER, DROP} arb_state_t;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned MAX_SRC = 8;
  localparam int unsigned SIZE_W  = 16;

  // Next source index after idx, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rx_cpu_arb_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping; one-hot grant plus index.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] idx_c
);

  logic        found;
  int unsigned cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req[IDX_W'(cand)]) begin
        found                  = 1'b1;
        grant_c[IDX_W'(cand)]  = 1'b1;
        idx_c                  = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rx_cpu_arb.sv
// Packet-granular round-robin admission arbiter in front of the CPU RX buffer.
// Define RX_CPU_ARB_STATS_EN to add per-source saturating drop/no-space counters.
module rx_cpu_arb
  import rx_cpu_arb_pkg::*;
#(
  parameter int unsigned N_SRC   = 2,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned EMPTY_W = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_SRC-1:0]           src_req_i,
  input  logic [N_SRC*SIZE_W-1:0]    src_size_i,
  input  logic [N_SRC*DATA_W-1:0]    src_data_i,
  input  logic [N_SRC-1:0]           src_sop_i,
  input  logic [N_SRC-1:0]           src_eop_i,
  input  logic [N_SRC*EMPTY_W-1:0]   src_empty_i,
  input  logic [N_SRC-1:0]           src_val_i,
  output logic [N_SRC-1:0]           src_ready_o,
  input  logic [SIZE_W-1:0]          cpu_mtu_i,
  output logic [SIZE_W-1:0]          buf_size_o,
  input  logic                       buf_wa_i,
  output logic [DATA_W-1:0]          buf_data_o,
  output logic                       buf_sop_o,
  output logic                       buf_eop_o,
  output logic [EMPTY_W-1:0]         buf_empty_o,
  output logic                       buf_val_o,
  input  logic                       buf_ready_i,
  output logic                       busy_o
`ifdef RX_CPU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]           drop_cnt_o    [N_SRC],
  output logic [CNT_W-1:0]           nospace_cnt_o [N_SRC]
`endif
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  if (N_SRC < 2 || N_SRC > MAX_SRC) begin : g_bad_cfg
    $error("rx_cpu_arb: N_SRC out of range");
  end

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt, idx_inc;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [SIZE_W-1:0] size_nxt;
  logic [N_SRC-1:0]  pick_grant_c;
  logic [IDX_W-1:0]  pick_idx_c;
  logic              oversize_c;

  logic [DATA_W-1:0]  data_a  [N_SRC];
  logic [SIZE_W-1:0]  size_a  [N_SRC];
  logic [EMPTY_W-1:0] empty_a [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign data_a[g]  = src_data_i[g*DATA_W +: DATA_W];
    assign size_a[g]  = src_size_i[g*SIZE_W +: SIZE_W];
    assign empty_a[g] = src_empty_i[g*EMPTY_W +: EMPTY_W];
  end

  rr_pick #(.N(N_SRC), .IDX_W(IDX_W)) u_pick (
    .req     (src_req_i),
    .ptr     (rr_ptr),
    .grant_c (pick_grant_c),
    .idx_c   (pick_idx_c)
  );

  assign idx_inc    = IDX_W'(wrap_inc(32'(idx), N_SRC));
  assign oversize_c = buf_size_o > cpu_mtu_i;
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      idx        <= '0;
      rr_ptr     <= '0;
      buf_size_o <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      rr_ptr     <= rr_ptr_nxt;
      buf_size_o <= size_nxt;
    end
  end

  // Next state plus the granted source's zero-latency beat path.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    rr_ptr_nxt  = rr_ptr;
    size_nxt    = buf_size_o;
    src_ready_o = '0;
    buf_data_o  = '0;
    buf_sop_o   = 1'b0;
    buf_eop_o   = 1'b0;
    buf_empty_o = '0;
    buf_val_o   = 1'b0;
    case (state)
      IDLE: begin
        if (|pick_grant_c) begin
          idx_nxt   = pick_idx_c;
          state_nxt = SIZE;
        end
      end
      SIZE: begin
        size_nxt  = size_a[idx];
        state_nxt = CHECK;
      end
      CHECK: begin
        if (oversize_c) begin
          state_nxt = DROP;
        end else if (buf_wa_i) begin
          state_nxt = XFER;
        end else begin
          // No room: yield to the next source instead of blocking the head.
          rr_ptr_nxt = idx_inc;
          state_nxt  = IDLE;
        end
      end
      XFER: begin
        src_ready_o[idx] = buf_ready_i;
        buf_data_o       = data_a[idx];
        buf_sop_o        = src_sop_i[idx];
        buf_eop_o        = src_eop_i[idx];
        buf_empty_o      = empty_a[idx];
        buf_val_o        = src_val_i[idx];
        if (src_val_i[idx] && buf_ready_i && src_eop_i[idx]) begin
          rr_ptr_nxt = idx_inc;
          state_nxt  = IDLE;
        end
      end
      DROP: begin
        src_ready_o[idx] = 1'b1;
        if (src_val_i[idx] && src_eop_i[idx]) begin
          rr_ptr_nxt = idx_inc;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RX_CPU_ARB_STATS_EN
  logic [N_SRC-1:0] drop_inc_c, nospace_inc_c;

  always_comb begin
    drop_inc_c    = '0;
    nospace_inc_c = '0;
    if (state == DROP && src_val_i[idx] && src_eop_i[idx]) drop_inc_c[idx] = 1'b1;
    if (state == CHECK && !oversize_c && !buf_wa_i)        nospace_inc_c[idx] = 1'b1;
  end

  // Saturating per-source event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_SRC; i++) begin
        drop_cnt_o[i]    <= '0;
        nospace_cnt_o[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (drop_inc_c[i] && drop_cnt_o[i] != '1)
          drop_cnt_o[i] <= drop_cnt_o[i] + CNT_W'(1);
        if (nospace_inc_c[i] && nospace_cnt_o[i] != '1)
          nospace_cnt_o[i] <= nospace_cnt_o[i] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_cpu_arb.sv
// Self-checking bench for rx_cpu_arb: per-source packet streams, in-order scoreboard, directed corners.
// Counter checks are compiled in when RX_CPU_ARB_STATS_EN is defined.
module tb_rx_cpu_arb;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 64;
  localparam int unsigned EW = 3;

  typedef struct { int unsigned size; int unsigned id; } pkt_t;
  typedef struct { int unsigned src; int unsigned size; int unsigned mtu; bit fwd; } vec_t;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [N-1:0]      src_req, src_sop, src_eop, src_val, src_ready;
  logic [N*16-1:0]   src_size;
  logic [N*DW-1:0]   src_data;
  logic [N*EW-1:0]   src_empty;
  logic [15:0]       cpu_mtu, buf_size;
  logic              buf_wa, buf_ready;
  logic [DW-1:0]     buf_data;
  logic              buf_sop, buf_eop, buf_val, busy;
  logic [EW-1:0]     buf_empty;
`ifdef RX_CPU_ARB_STATS_EN
  logic [31:0]       drop_cnt    [N];
  logic [31:0]       nospace_cnt [N];
`endif

  always #5 clk = ~clk;

  rx_cpu_arb #(.N_SRC(N), .DATA_W(DW), .EMPTY_W(EW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .src_req_i   (src_req),
    .src_size_i  (src_size),
    .src_data_i  (src_data),
    .src_sop_i   (src_sop),
    .src_eop_i   (src_eop),
    .src_empty_i (src_empty),
    .src_val_i   (src_val),
    .src_ready_o (src_ready),
    .cpu_mtu_i   (cpu_mtu),
    .buf_size_o  (buf_size),
    .buf_wa_i    (buf_wa),
    .buf_data_o  (buf_data),
    .buf_sop_o   (buf_sop),
    .buf_eop_o   (buf_eop),
    .buf_empty_o (buf_empty),
    .buf_val_o   (buf_val),
    .buf_ready_i (buf_ready),
    .busy_o      (busy)
`ifdef RX_CPU_ARB_STATS_EN
    ,
    .drop_cnt_o    (drop_cnt),
    .nospace_cnt_o (nospace_cnt)
`endif
  );

  pkt_t        src_q [N][$];
  pkt_t        exp_q [N][$];
  int unsigned bidx [N];
  bit          fire [N];
  int unsigned exp_drop [N];
  int unsigned out_order [$];
  int unsigned pkts_done, next_id, ncyc;
  bit          in_pkt;
  int unsigned cur_s, cur_id, cur_b, cur_n, cur_size;
  bit          gap_en, rdy_rand;
  int unsigned wa_mode, wa_block;
  int          n_pass, n_chk;
  bit          trk;
  int unsigned trk_s;
  int          req_cyc, rdy_cyc;
  logic        rdy_val, rdy_busy;
  logic [15:0] rdy_size;

  function automatic int unsigned nbeats(input int unsigned sz);
    return (sz == 0) ? 1 : (sz + 7) / 8;
  endfunction

  function automatic int unsigned tail_empty(input int unsigned sz);
    return (8 - sz % 8) % 8;
  endfunction

  function automatic bit all_empty();
    for (int s = 0; s < N; s++) if (src_q[s].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, ncyc);
  endtask

  task automatic drive();
    pkt_t        p;
    int unsigned nb;
    for (int s = 0; s < N; s++) begin
      src_req[s] = 1'b0; src_sop[s] = 1'b0; src_eop[s] = 1'b0; src_val[s] = 1'b0;
      src_size[s*16 +: 16]  = '0;
      src_data[s*DW +: DW]  = '0;
      src_empty[s*EW +: EW] = '0;
      if (src_q[s].size() > 0) begin
        p  = src_q[s][0];
        nb = nbeats(p.size);
        src_req[s]           = (bidx[s] == 0);
        src_size[s*16 +: 16] = 16'(p.size);
        src_data[s*DW +: DW] = {8'(s), 24'(p.id), 32'(bidx[s])};
        src_sop[s]           = (bidx[s] == 0);
        src_eop[s]           = (bidx[s] == nb - 1);
        if (bidx[s] == nb - 1) src_empty[s*EW +: EW] = EW'(tail_empty(p.size));
        src_val[s]           = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
    buf_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    case (wa_mode)
      0:       buf_wa = 1'b1;
      1:       buf_wa = ($urandom_range(0, 9) < 7);
      default: buf_wa = (32'(buf_size) != wa_block);
    endcase
  endtask

  task automatic out_beat();
    int unsigned s, id, b;
    s  = 32'(buf_data[63:56]);
    id = 32'(buf_data[55:32]);
    b  = buf_data[31:0];
    if (!in_pkt) begin
      if (s >= N || exp_q[s].size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pkt: got src %0d id %0d, required no packet (cycle %0d)", s, id, ncyc);
        return;
      end
      chk("pkt_id", 64'(id), 64'(exp_q[s][0].id));
      in_pkt   = 1'b1;
      cur_s    = s;
      cur_id   = exp_q[s][0].id;
      cur_size = exp_q[s][0].size;
      cur_n    = nbeats(cur_size);
      cur_b    = 0;
      out_order.push_back(s);
    end else begin
      chk("no_interleave", {s, id}, {cur_s, cur_id});
    end
    chk("beat_seq", 64'(b), 64'(cur_b));
    chk("sop", 64'(buf_sop), 64'(cur_b == 0));
    chk("eop", 64'(buf_eop), 64'(cur_b == cur_n - 1));
    if (cur_b == cur_n - 1) begin
      chk("empty", 64'(buf_empty), 64'(tail_empty(cur_size)));
      void'(exp_q[cur_s].pop_front());
      in_pkt = 1'b0;
      pkts_done++;
    end
    cur_b++;
  endtask

  task automatic sample();
    for (int s = 0; s < N; s++) fire[s] = src_val[s] && src_ready[s];
    if (trk) begin
      if (req_cyc < 0 && src_req[trk_s]) req_cyc = int'(ncyc);
      if (rdy_cyc < 0 && src_ready[trk_s]) begin
        rdy_cyc  = int'(ncyc);
        rdy_val  = buf_val;
        rdy_busy = busy;
        rdy_size = buf_size;
      end
    end
    if (buf_val && buf_ready) out_beat();
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int s = 0; s < N; s++) begin
      if (fire[s]) begin
        fire[s] = 1'b0;
        bidx[s]++;
        if (bidx[s] == nbeats(src_q[s][0].size)) begin
          void'(src_q[s].pop_front());
          bidx[s] = 0;
        end
      end
    end
    drive();
    @(negedge clk);
    ncyc++;
    sample();
  endtask

  task automatic add_pkt(input int unsigned s, input int unsigned sz);
    pkt_t p;
    p.size = sz;
    p.id   = next_id;
    next_id++;
    src_q[s].push_back(p);
    if (sz <= 32'(cpu_mtu)) exp_q[s].push_back(p);
    else exp_drop[s]++;
  endtask

  task automatic run_idle(input string name, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (!(all_empty() && !in_pkt && busy == 1'b0) && k < budget) begin
      cycle();
      k++;
    end
    chk(name, 64'(all_empty() && !in_pkt && busy == 1'b0), 64'd1);
    for (int s = 0; s < N; s++) chk("exp_drained", 64'(exp_q[s].size()), 64'd0);
  endtask

  task automatic check_drops();
`ifdef RX_CPU_ARB_STATS_EN
    for (int s = 0; s < N; s++) chk("drop_cnt", 64'(drop_cnt[s]), 64'(exp_drop[s]));
`endif
  endtask

  // Synchronous reset for one cycle; abandons any source traffic in flight.
  task automatic do_reset();
    rst_i = 1'b1;
    for (int s = 0; s < N; s++) begin
      src_q[s].delete();
      exp_q[s].delete();
      bidx[s] = 0; fire[s] = 1'b0; exp_drop[s] = 0;
    end
    in_pkt = 1'b0;
    out_order.delete();
    pkts_done = 0;
    drive();
    @(posedge clk);
    #1;
    @(negedge clk);
    ncyc++;
    chk("rst_buf_val", 64'(buf_val), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_buf_size", 64'(buf_size), 64'd0);
    chk("rst_buf_data", buf_data, 64'd0);
`ifdef RX_CPU_ARB_STATS_EN
    for (int s = 0; s < N; s++) begin
      chk("rst_drop_cnt", 64'(drop_cnt[s]), 64'd0);
      chk("rst_nospace_cnt", 64'(nospace_cnt[s]), 64'd0);
    end
`endif
    rst_i = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    int unsigned k;
    n_pass = 0; n_chk = 0; ncyc = 0; next_id = 1; trk = 1'b0;
    gap_en = 1'b0; rdy_rand = 1'b0; wa_mode = 0; wa_block = 0;
    cpu_mtu = 16'd1518; pkts_done = 0; in_pkt = 1'b0;
    cur_s = 0; cur_id = 0; cur_b = 0; cur_n = 0; cur_size = 0;
    req_cyc = -1; rdy_cyc = -1; trk_s = 0;
    rdy_val = 1'b0; rdy_busy = 1'b0; rdy_size = '0;
    for (int s = 0; s < N; s++) begin bidx[s] = 0; fire[s] = 1'b0; exp_drop[s] = 0; end
    do_reset();

    // Single-packet vectors: forward/drop decision, grant latency, latched size.
    vecs[0] = '{src: 0, size: 64,   mtu: 1518, fwd: 1'b1};
    vecs[1] = '{src: 1, size: 1518, mtu: 1518, fwd: 1'b1};
    vecs[2] = '{src: 0, size: 1519, mtu: 1518, fwd: 1'b0};
    vecs[3] = '{src: 1, size: 2000, mtu: 1518, fwd: 1'b0};
    vecs[4] = '{src: 0, size: 0,    mtu: 1518, fwd: 1'b1};
    vecs[5] = '{src: 1, size: 9,    mtu: 8,    fwd: 1'b0};
    vecs[6] = '{src: 0, size: 8,    mtu: 8,    fwd: 1'b1};
    vecs[7] = '{src: 1, size: 1,    mtu: 0,    fwd: 1'b0};
    for (int i = 0; i < 8; i++) begin
      cpu_mtu = 16'(vecs[i].mtu);
      add_pkt(vecs[i].src, vecs[i].size);
      trk = 1'b1; trk_s = vecs[i].src; req_cyc = -1; rdy_cyc = -1;
      run_idle($sformatf("vec%0d_done", i), 2000);
      trk = 1'b0;
      chk("grant_latency", 64'(rdy_cyc - req_cyc), 64'd3);
      chk("fwd_or_drop", 64'(rdy_val), 64'(vecs[i].fwd));
      chk("size_latched", 64'(rdy_size), 64'(vecs[i].size));
      chk("busy_in_grant", 64'(rdy_busy), 64'd1);
    end
    check_drops();

    // Randomized traffic: gaps, buffer back-pressure and random room.
    cpu_mtu = 16'd600; gap_en = 1'b1; rdy_rand = 1'b1; wa_mode = 1;
    add_pkt(0, 600); add_pkt(1, 601); add_pkt(1, 0);
    for (int i = 0; i < 40; i++) add_pkt($urandom_range(0, N - 1), $urandom_range(0, 700));
    run_idle("random_done", 40000);
    check_drops();
    gap_en = 1'b0; rdy_rand = 1'b0; wa_mode = 0;

    // Both sources always requesting: grants must alternate.
    do_reset();
    cpu_mtu = 16'd1518;
    for (int i = 0; i < 10; i++) begin
      add_pkt(0, 8 + 8 * i);
      add_pkt(1, 24 + 4 * i);
    end
    run_idle("rr_done", 3000);
    chk("rr_count", 64'(out_order.size()), 64'd20);
    for (int i = 0; i < out_order.size(); i++) chk("rr_order", 64'(out_order[i]), 64'(i % 2));

    // No room for src0: it is skipped, src1 goes first, src0 follows once room appears.
    do_reset();
    wa_mode = 2; wa_block = 100;
    add_pkt(0, 100); add_pkt(1, 64);
    k = 0;
    while (pkts_done < 1 && k < 500) begin cycle(); k++; end
    wa_mode = 0;
    run_idle("nospace_done", 500);
    chk("nospace_count", 64'(out_order.size()), 64'd2);
    chk("nospace_first", 64'(out_order.size() > 0 ? out_order[0] : 99), 64'd1);
    chk("nospace_second", 64'(out_order.size() > 1 ? out_order[1] : 99), 64'd0);
`ifdef RX_CPU_ARB_STATS_EN
    chk("nospace_cnt0", 64'(nospace_cnt[0]), 64'd1);
    chk("nospace_cnt1", 64'(nospace_cnt[1]), 64'd0);
`endif

    // Reset in the middle of a src1 transfer; pointer must restart at src0.
    do_reset();
    add_pkt(0, 16);
    run_idle("pre_rst_done", 200);
    add_pkt(1, 64);
    k = 0;
    while (!(in_pkt && cur_b >= 3) && k < 100) begin cycle(); k++; end
    chk("reached_mid_xfer", 64'(in_pkt), 64'd1);
    do_reset();
    add_pkt(1, 16); add_pkt(0, 16);
    run_idle("post_rst_done", 200);
    chk("post_rst_first", 64'(out_order.size() > 0 ? out_order[0] : 99), 64'd0);
    chk("post_rst_second", 64'(out_order.size() > 1 ? out_order[1] : 99), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
